// File: rtl/jt49_eg_pkg.sv
// Shared definitions for the multi-channel envelope generator: shape-control
// bit positions and the hold/invert decode used at the end of each ramp.
package jt49_eg_pkg;

    localparam int CONT_B = 3;
    localparam int ATT_B  = 2;
    localparam int ALT_B  = 1;
    localparam int HOLD_B = 0;

    // Shape stops at the end of the current ramp
    function automatic logic will_hold(input logic [3:0] ctrl);
        return !ctrl[CONT_B] || ctrl[HOLD_B];
    endfunction

    // Shape flips direction at the end of the current ramp
    function automatic logic will_invert(input logic [3:0] ctrl);
        return (!ctrl[CONT_B] && ctrl[ATT_B]) || (ctrl[CONT_B] && ctrl[ALT_B]);
    endfunction

endpackage

// File: rtl/jt49_eg_ch.sv
// One envelope channel: restart latch, period counter, gain/inv/stop state and
// the registered envelope output.
module jt49_eg_ch
    import jt49_eg_pkg::*;
#(
    parameter int unsigned PW = 16,
    parameter int unsigned GW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          freeze,
    input  logic          restart,
    input  logic [PW-1:0] period,
    input  logic [3:0]    ctrl,
    output logic [GW-1:0] env,
    output logic          done
);

    logic [PW-1:0] cnt_q, cnt_d, eff;
    logic [GW-1:0] gain_q, gain_d, env_q;
    logic          inv_q, inv_d, stop_q, stop_d, latch_q, step;

    always_comb begin
        eff    = (period == '0) ? PW'(1) : period;
        cnt_d  = cnt_q;
        gain_d = gain_q;
        inv_d  = inv_q;
        stop_d = stop_q;
        step   = 1'b0;
        if (latch_q) begin
            gain_d = '1;
            inv_d  = ctrl[ATT_B];
            stop_d = 1'b0;
            cnt_d  = '0;
        end else if (!freeze) begin
            // >= rather than == so a shortened period takes effect at once
            if (cnt_q >= eff - PW'(1)) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + PW'(1);
            end
            if (step && !stop_q) begin
                if (gain_q != '0) begin
                    gain_d = gain_q - GW'(1);
                end else begin
                    if (will_invert(ctrl)) inv_d = !inv_q;
                    if (will_hold(ctrl)) stop_d = 1'b1;
                    else                 gain_d = '1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            gain_q  <= '1;
            inv_q   <= 1'b0;
            stop_q  <= 1'b0;
            latch_q <= 1'b0;
            env_q   <= '0;
        end else begin
            // Restart requests can arrive on any clk; hold them until a cen services them
            if (cen && latch_q) latch_q <= 1'b0;
            else if (restart)   latch_q <= 1'b1;
            if (cen) begin
                cnt_q  <= cnt_d;
                gain_q <= gain_d;
                inv_q  <= inv_d;
                stop_q <= stop_d;
                env_q  <= inv_q ? ~gain_q : gain_q;
            end
        end
    end

    assign env  = env_q;
    assign done = stop_q;

endmodule

// File: rtl/jt49_eg_multi.sv
// Multi-channel PSG envelope generator: slices the packed per-channel buses
// and instantiates one independent envelope channel per slice.
module jt49_eg_multi
    import jt49_eg_pkg::*;
#(
    parameter int unsigned NCH = 1,
    parameter int unsigned PW  = 16,
    parameter int unsigned GW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [NCH*PW-1:0] period,
    input  logic [NCH*4-1:0]  ctrl,
    input  logic [NCH-1:0]    restart,
    input  logic              freeze,
    output logic [NCH*GW-1:0] env,
    output logic [NCH-1:0]    done
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        jt49_eg_ch #(
            .PW (PW),
            .GW (GW)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cen     (cen),
            .freeze  (freeze),
            .restart (restart[i]),
            .period  (period[i*PW +: PW]),
            .ctrl    (ctrl[i*4 +: 4]),
            .env     (env[i*GW +: GW]),
            .done    (done[i])
        );
    end

endmodule

// File: tb/tb_jt49_eg_multi.sv
// Directed self-checking bench: a 3-channel 5-bit instance and a 1-channel
// 4-bit instance share clock, cen, freeze and reset.
module tb_jt49_eg_multi;

    logic        clk = 1'b0;
    logic        rst_n, cen, freeze;
    logic [47:0] period_a;
    logic [11:0] ctrl_a;
    logic [2:0]  restart_a;
    logic [14:0] env_a;
    logic [2:0]  done_a;
    logic [15:0] period_b;
    logic [3:0]  ctrl_b;
    logic        restart_b;
    logic [3:0]  env_b;
    logic        done_b;

    int errors = 0;
    int checks = 0;

    jt49_eg_multi #(.NCH(3), .PW(16), .GW(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .cen(cen), .period(period_a), .ctrl(ctrl_a),
        .restart(restart_a), .freeze(freeze), .env(env_a), .done(done_a)
    );

    jt49_eg_multi #(.NCH(1), .PW(16), .GW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .cen(cen), .period(period_b), .ctrl(ctrl_b),
        .restart(restart_b), .freeze(freeze), .env(env_b), .done(done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Restart channel 0 (pulse, then the servicing cen)
    task automatic restart_ch0(input logic [15:0] p, input logic [3:0] c);
        period_a[15:0] = p;
        ctrl_a[3:0]    = c;
        restart_a      = 3'b001;
        tick();
        restart_a = 3'b000;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (env_a !== 15'd0 || done_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_a env=%h done=%b expected 0/0", env_a, done_a);
        end
        checks++;
        if (env_b !== 4'd0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b env=%h done=%b expected 0/0", env_b, done_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_saw(input logic [15:0] p, input int n);
        int e;
        restart_ch0(p, 4'b1000);
        for (int k = 1; k <= n; k++) begin
            tick();
            e = (32 - k) & 31;
            checks++;
            if (env_a[4:0] !== 5'(e) || done_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL saw p=%0d k=%0d env=%0d done=%b expected %0d/0",
                         p, k, env_a[4:0], done_a[0], e);
            end
        end
    endtask

    task automatic test_decay_hold;
        int s, e;
        logic d;
        restart_ch0(16'd2, 4'b0000);
        for (int k = 1; k <= 164; k++) begin
            tick();
            s = (k - 1) / 2;
            e = (s > 31) ? 0 : 31 - s;
            d = (k >= 64);
            checks++;
            if (env_a[4:0] !== 5'(e) || done_a[0] !== d) begin
                errors++;
                $display("FAIL decay k=%0d env=%0d done=%b expected %0d/%b",
                         k, env_a[4:0], done_a[0], e, d);
            end
        end
    endtask

    task automatic test_attack_hold;
        int s, e;
        logic d;
        restart_ch0(16'd1, 4'b1101);
        for (int k = 1; k <= 40; k++) begin
            tick();
            s = k - 1;
            e = (s > 31) ? 31 : s;
            d = (k >= 32);
            checks++;
            if (env_a[4:0] !== 5'(e) || done_a[0] !== d) begin
                errors++;
                $display("FAIL attack k=%0d env=%0d done=%b expected %0d/%b",
                         k, env_a[4:0], done_a[0], e, d);
            end
        end
    endtask

    // Triangle with ATT=1 starts inverted, so it rises first
    task automatic test_triangle;
        int s, e;
        period_b  = 16'd3;
        ctrl_b    = 4'b1110;
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        tick();
        for (int k = 1; k <= 120; k++) begin
            tick();
            s = (k - 1) / 3;
            e = (((s / 16) % 2) == 0) ? (s % 16) : 15 - (s % 16);
            checks++;
            if (env_b !== 4'(e) || done_b !== 1'b0) begin
                errors++;
                $display("FAIL triangle k=%0d env=%0d done=%b expected %0d/0",
                         k, env_b, done_b, e);
            end
        end
    endtask

    task automatic test_restart_freeze;
        int exp_r [4] = '{12, 11, 31, 30};
        restart_ch0(16'd1, 4'b1000);
        for (int k = 1; k <= 19; k++) tick();
        restart_a = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            restart_a = 3'b000;
            checks++;
            if (env_a[4:0] !== 5'(exp_r[i])) begin
                errors++;
                $display("FAIL restart i=%0d env=%0d expected %0d", i, env_a[4:0], exp_r[i]);
            end
        end
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (env_a[4:0] !== 5'd29) begin
                errors++;
                $display("FAIL freeze i=%0d env=%0d expected 29", i, env_a[4:0]);
            end
        end
        freeze = 1'b0;
        tick();
        checks++;
        if (env_a[4:0] !== 5'd29) begin
            errors++;
            $display("FAIL unfreeze0 env=%0d expected 29", env_a[4:0]);
        end
        tick();
        checks++;
        if (env_a[4:0] !== 5'd28) begin
            errors++;
            $display("FAIL unfreeze1 env=%0d expected 28", env_a[4:0]);
        end
        // Reset coinciding with a restart request wins
        restart_a = 3'b001;
        rst_n     = 1'b0;
        tick();
        restart_a = 3'b000;
        rst_n     = 1'b1;
        checks++;
        if (env_a !== 15'd0 || done_a !== 3'd0 || env_b !== 4'd0) begin
            errors++;
            $display("FAIL midreset env_a=%h done_a=%b env_b=%h expected 0", env_a, done_a,
                     env_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (env_a[4:0] !== 5'(31 - i)) begin
                errors++;
                $display("FAIL postreset i=%0d env=%0d expected %0d", i, env_a[4:0], 31 - i);
            end
        end
    endtask

    task automatic test_cen;
        int exp_c [3] = '{28, 31, 30};
        cen       = 1'b0;
        restart_a = 3'b001;
        tick();
        restart_a = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (env_a[4:0] !== 5'd29) begin
                errors++;
                $display("FAIL cen_hold i=%0d env=%0d expected 29", i, env_a[4:0]);
            end
        end
        cen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (env_a[4:0] !== 5'(exp_c[i])) begin
                errors++;
                $display("FAIL cen_restart i=%0d env=%0d expected %0d", i, env_a[4:0],
                         exp_c[i]);
            end
        end
        // A latched restart still pending at reset must be discarded
        cen       = 1'b0;
        restart_a = 3'b001;
        tick();
        restart_a = 3'b000;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        cen   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (env_a[4:0] !== 5'(31 - i) || done_a[0] !== 1'b0) begin
                errors++;
                $display("FAIL pending_reset i=%0d env=%0d done=%b expected %0d/0",
                         i, env_a[4:0], done_a[0], 31 - i);
            end
        end
    endtask

    task automatic test_multi;
        int s1, s2, e0, e1, e2;
        logic [2:0] d;
        period_a  = {16'd3, 16'd2, 16'd1};
        ctrl_a    = {4'b1101, 4'b0000, 4'b1000};
        restart_a = 3'b111;
        tick();
        restart_a = 3'b000;
        tick();
        for (int k = 1; k <= 100; k++) begin
            tick();
            s1 = (k - 1) / 2;
            s2 = (k - 1) / 3;
            e0 = (32 - k) & 31;
            e1 = (s1 > 31) ? 0 : 31 - s1;
            e2 = (s2 > 31) ? 31 : s2;
            d  = {k >= 96, k >= 64, 1'b0};
            checks++;
            if (env_a !== {5'(e2), 5'(e1), 5'(e0)} || done_a !== d) begin
                errors++;
                $display("FAIL multi k=%0d env=%0d,%0d,%0d done=%b expected %0d,%0d,%0d/%b",
                         k, env_a[14:10], env_a[9:5], env_a[4:0], done_a, e2, e1, e0, d);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        cen       = 1'b1;
        freeze    = 1'b0;
        period_a  = '0;
        ctrl_a    = '0;
        restart_a = '0;
        period_b  = '0;
        ctrl_b    = '0;
        restart_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_saw(16'd1, 70);
        test_saw(16'd0, 40);
        test_decay_hold();
        test_attack_hold();
        test_triangle();
        test_restart_freeze();
        test_cen();
        test_multi();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
